// File: rtl/ext_bus_pkg.sv
// Shared types and widths for the external Arduino bus arbiter.
package ext_bus_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned ADDR_W = 16;

  typedef enum logic [3:0] {
    IDLE,
    WAIT_RDY,
    ADDR_HI,
    ADDR_LO,
    DATA_HI,
    DATA_LO,
    WAIT_RESP,
    RESP_HI,
    RESP_LO,
    DONE
  } arb_state_t;

  typedef enum logic {REQ_FETCH, REQ_MEM} req_id_t;

endpackage

// File: rtl/wait_timer.sv
// Host-wait watchdog: counts enabled cycles and flags the TIMEOUT-th waiting cycle.
module wait_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TIMEOUT);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  logic [CntW-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (en && (r_count != CntMax)) begin
      r_count <= r_count + CntW'(1);
    end
  end

  // The count holds completed wait cycles, so the current cycle is the TIMEOUT-th at CntLast.
  assign expired = en && (r_count >= CntLast);

endmodule

// File: rtl/ext_bus_arbiter.sv
// Round-robin arbiter between fetch and load/store for the 8-bit Arduino host link.
module ext_bus_arbiter
  import ext_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_done,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [ADDR_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_done,
  output logic [ADDR_W-1:0] rdata,
  output logic              txn_err,
  output logic              err_sticky,
  input  logic              ard_receive_ready,
  input  logic              ard_data_ready,
  input  logic [BYTE_W-1:0] bus_in,
  output logic [BYTE_W-1:0] bus_out,
  output logic              bus_oe,
  output logic              bus_we,
  output logic              busy
);

  arb_state_t        r_state, w_next;
  req_id_t           r_owner, r_last;
  logic [ADDR_W-1:0] r_addr, r_wdata, r_rdata;
  logic              r_we, r_err, r_sticky;

  logic w_idle, w_pick_mem, w_gnt_fetch, w_gnt_mem;
  logic w_waiting, w_expired;

  // Grant is Mealy in IDLE; suppressed while rst is high so reset cycles show all-zero outputs.
  assign w_idle      = (r_state == IDLE) && !rst;
  assign w_pick_mem  = mem_req && (!fetch_req || (r_last == REQ_FETCH));
  assign w_gnt_mem   = w_idle && w_pick_mem;
  assign w_gnt_fetch = w_idle && fetch_req && !w_pick_mem;

  assign w_waiting = (r_state == WAIT_RDY) || (r_state == WAIT_RESP);

  wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_wait_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (!w_waiting),
    .en     (w_waiting),
    .expired(w_expired)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_gnt_fetch || w_gnt_mem) w_next = WAIT_RDY;
      WAIT_RDY: begin
        if (ard_receive_ready) w_next = ADDR_HI;
        else if (w_expired)    w_next = DONE;
      end
      ADDR_HI:   w_next = ADDR_LO;
      ADDR_LO:   w_next = r_we ? DATA_HI : WAIT_RESP;
      DATA_HI:   w_next = DATA_LO;
      DATA_LO:   w_next = DONE;
      WAIT_RESP: begin
        if (ard_data_ready) w_next = RESP_LO;
        else if (w_expired) w_next = DONE;
      end
      RESP_HI:   w_next = RESP_LO;
      RESP_LO:   w_next = DONE;
      DONE:      w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_owner  <= REQ_FETCH;
      r_last   <= REQ_FETCH;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_sticky <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_gnt_fetch) begin
        r_owner <= REQ_FETCH;
        r_addr  <= fetch_addr;
        r_we    <= 1'b0;
        r_wdata <= '0;
      end
      if (w_gnt_mem) begin
        r_owner <= REQ_MEM;
        r_addr  <= mem_addr;
        r_we    <= mem_we;
        r_wdata <= mem_wdata;
      end
      case (r_state)
        WAIT_RDY: begin
          if (!ard_receive_ready && w_expired) begin
            r_err    <= 1'b1;
            r_sticky <= 1'b1;
            r_rdata  <= '0;
          end
        end
        WAIT_RESP: begin
          if (ard_data_ready) begin
            r_rdata[15:8] <= bus_in;
          end else if (w_expired) begin
            r_err    <= 1'b1;
            r_sticky <= 1'b1;
            r_rdata  <= '0;
          end
        end
        RESP_LO: r_rdata[7:0] <= bus_in;
        DONE: begin
          r_last <= r_owner;
          r_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_out = '0;
    bus_oe  = 1'b1;
    case (r_state)
      ADDR_HI: bus_out = r_addr[15:8];
      ADDR_LO: bus_out = r_addr[7:0];
      DATA_HI: bus_out = r_wdata[15:8];
      DATA_LO: bus_out = r_wdata[7:0];
      default: bus_oe  = 1'b0;
    endcase
  end

  assign busy       = (r_state != IDLE);
  assign bus_we     = busy && r_we;
  assign fetch_gnt  = w_gnt_fetch;
  assign mem_gnt    = w_gnt_mem;
  assign fetch_done = (r_state == DONE) && (r_owner == REQ_FETCH);
  assign mem_done   = (r_state == DONE) && (r_owner == REQ_MEM);
  assign txn_err    = (r_state == DONE) && r_err;
  assign rdata      = r_rdata;
  assign err_sticky = r_sticky;

endmodule

// File: tb/tb_ext_bus_arbiter.sv
// Directed bench for ext_bus_arbiter with TIMEOUT = 15.
module tb_ext_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_req, fetch_gnt, fetch_done;
  logic [15:0] fetch_addr;
  logic        mem_req, mem_we, mem_gnt, mem_done;
  logic [15:0] mem_addr, mem_wdata, rdata;
  logic        txn_err, err_sticky;
  logic        ard_receive_ready, ard_data_ready;
  logic [7:0]  bus_in, bus_out;
  logic        bus_oe, bus_we, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ext_bus_arbiter #(
    .TIMEOUT(15)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_req        (fetch_req),
    .fetch_addr       (fetch_addr),
    .fetch_gnt        (fetch_gnt),
    .fetch_done       (fetch_done),
    .mem_req          (mem_req),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_gnt          (mem_gnt),
    .mem_done         (mem_done),
    .rdata            (rdata),
    .txn_err          (txn_err),
    .err_sticky       (err_sticky),
    .ard_receive_ready(ard_receive_ready),
    .ard_data_ready   (ard_data_ready),
    .bus_in           (bus_in),
    .bus_out          (bus_out),
    .bus_oe           (bus_oe),
    .bus_we           (bus_we),
    .busy             (busy)
  );

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 1'b0);
    check_eq({tag, "_oe"}, bus_oe, 1'b0);
    check_eq({tag, "_out"}, bus_out, 8'h00);
    check_eq({tag, "_we"}, bus_we, 1'b0);
    check_eq({tag, "_gnt"}, {fetch_gnt, mem_gnt}, 2'b00);
    check_eq({tag, "_done"}, {fetch_done, mem_done}, 2'b00);
    check_eq({tag, "_err"}, txn_err, 1'b0);
    check_eq({tag, "_sticky"}, err_sticky, 1'b0);
    check_eq({tag, "_rdata"}, rdata, 16'h0000);
  endtask

  logic [7:0] store_bytes [4];
  logic [1:0] exp_gnt;

  initial begin
    store_bytes = '{8'h00, 8'hF0, 8'hBE, 8'hEF};
    rst = 1'b1;
    fetch_req = 1'b0; fetch_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    ard_receive_ready = 1'b0; ard_data_ready = 1'b0; bus_in = '0;

    tick(); tick(); settle();
    check_all_zero("reset");
    rst = 1'b0;

    // Single fetch of 0x1234, response AB CD
    tick();
    fetch_req = 1'b1; fetch_addr = 16'h1234; ard_receive_ready = 1'b1; settle();
    check_eq("t1_c0_fetch_gnt", fetch_gnt, 1'b1);
    check_eq("t1_c0_mem_gnt", mem_gnt, 1'b0);
    tick(); fetch_req = 1'b0; settle();
    check_eq("t1_c1_busy", busy, 1'b1);
    check_eq("t1_c1_oe", bus_oe, 1'b0);
    tick(); settle();
    check_eq("t1_c2_out", bus_out, 8'h12);
    check_eq("t1_c2_oe", bus_oe, 1'b1);
    check_eq("t1_c2_we", bus_we, 1'b0);
    tick(); settle();
    check_eq("t1_c3_out", bus_out, 8'h34);
    tick(); ard_data_ready = 1'b1; bus_in = 8'hAB; settle();
    check_eq("t1_c4_oe", bus_oe, 1'b0);
    tick(); ard_data_ready = 1'b0; bus_in = 8'hCD; settle();
    check_eq("t1_c5_done", fetch_done, 1'b0);
    tick(); settle();
    check_eq("t1_c6_done", fetch_done, 1'b1);
    check_eq("t1_c6_rdata", rdata, 16'hABCD);
    check_eq("t1_c6_err", txn_err, 1'b0);
    check_eq("t1_c6_we", bus_we, 1'b0);
    tick(); settle();
    check_eq("t1_c7_busy", busy, 1'b0);
    check_eq("t1_c7_done", fetch_done, 1'b0);

    // Store 0xBEEF to 0x00F0
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h00F0; mem_wdata = 16'hBEEF; settle();
    check_eq("t2_c0_gnt", {fetch_gnt, mem_gnt}, 2'b01);
    tick(); mem_req = 1'b0; settle();
    check_eq("t2_c1_fetch", {fetch_gnt, fetch_done}, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick(); settle();
      check_eq($sformatf("t2_c%0d_out", i + 2), bus_out, store_bytes[i]);
      check_eq($sformatf("t2_c%0d_we", i + 2), bus_we, 1'b1);
      check_eq($sformatf("t2_c%0d_fetch", i + 2), {fetch_gnt, fetch_done}, 2'b00);
    end
    tick(); settle();
    check_eq("t2_c6_done", {fetch_done, mem_done}, 2'b01);
    check_eq("t2_c6_rdata_hold", rdata, 16'hABCD);
    tick(); settle();
    check_eq("t2_c7_busy", busy, 1'b0);

    // Both requesting continuously from reset: mem, fetch, mem, fetch every 7 cycles
    rst = 1'b1;
    tick();
    rst = 1'b0; fetch_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; ard_data_ready = 1'b1;
    for (int k = 0; k < 28; k++) begin
      settle();
      if (k % 7 != 0)          exp_gnt = 2'b00;
      else if ((k / 7) % 2 == 0) exp_gnt = 2'b01;
      else                     exp_gnt = 2'b10;
      check_eq($sformatf("t3_c%0d_gnt", k), {fetch_gnt, mem_gnt}, exp_gnt);
      tick();
    end
    fetch_req = 1'b0; mem_req = 1'b0; ard_data_ready = 1'b0;

    // Host never ready: abort after 15 WAIT_RDY cycles
    ard_receive_ready = 1'b0; fetch_req = 1'b1; fetch_addr = 16'h4321; settle();
    check_eq("t4_c0_gnt", {fetch_gnt, mem_gnt}, 2'b10);
    tick(); fetch_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      settle();
      check_eq($sformatf("t4_c%0d_wait", i), {busy, fetch_done, bus_oe}, 3'b100);
      if (i == 15) check_eq("t4_c15_sticky", err_sticky, 1'b0);
      tick();
    end
    settle();
    check_eq("t4_c16_done", fetch_done, 1'b1);
    check_eq("t4_c16_err", txn_err, 1'b1);
    check_eq("t4_c16_rdata", rdata, 16'h0000);
    check_eq("t4_c16_sticky", err_sticky, 1'b1);
    tick(); settle();
    check_eq("t4_c17_busy", busy, 1'b0);
    check_eq("t4_c17_err", txn_err, 1'b0);
    ard_receive_ready = 1'b1; mem_req = 1'b1; mem_we = 1'b1;
    mem_addr = 16'h0102; mem_wdata = 16'h0304; settle();
    check_eq("t4_s_gnt", mem_gnt, 1'b1);
    tick(); mem_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    settle();
    check_eq("t4_s_done", mem_done, 1'b1);
    check_eq("t4_s_err", txn_err, 1'b0);
    check_eq("t4_s_sticky", err_sticky, 1'b1);
    tick();

    // Reset during ADDR_LO of a store
    mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'hAA55; mem_wdata = 16'h5555; settle();
    check_eq("t5_c0_gnt", mem_gnt, 1'b1);
    tick(); mem_req = 1'b0;
    tick(); tick(); settle();
    check_eq("t5_c3_out", bus_out, 8'h55);
    rst = 1'b1;
    tick();
    fetch_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0; ard_data_ready = 1'b1; bus_in = 8'hCD;
    settle();
    check_all_zero("t5_rst");
    rst = 1'b0; settle();
    check_eq("t5_tie_gnt", {fetch_gnt, mem_gnt}, 2'b01);
    tick(); fetch_req = 1'b0; mem_req = 1'b0; settle();
    check_eq("t5_c1_busy", {busy, mem_done}, 2'b10);
    for (int i = 0; i < 5; i++) tick();
    settle();
    check_eq("t5_c6_done", {fetch_done, mem_done}, 2'b01);
    check_eq("t5_c6_rdata", rdata, 16'hCDCD);
    tick();

    // Address change after grant must not affect bytes sent
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h1111; settle();
    check_eq("t6_c0_gnt", mem_gnt, 1'b1);
    tick(); mem_req = 1'b0; mem_addr = 16'h2222;
    tick(); settle();
    check_eq("t6_c2_out", bus_out, 8'h11);
    tick(); settle();
    check_eq("t6_c3_out", bus_out, 8'h11);
    tick(); tick(); tick(); settle();
    check_eq("t6_c6_done", mem_done, 1'b1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ext_bus_arbiter.md
# ext_bus_arbiter

Arbitrates the single 8-bit external link to the Arduino memory host between two 16-bit requesters: the instruction-fetch path and the load/store path. Each granted transaction is sequenced byte by byte:
- Reads: address out, then response in.
- Writes: address out, then data out.

A timeout guards every wait on the host. The block sits between the CPU core control FSM and the external pins, replacing ad-hoc bus-select strobes with a request/grant/done handshake.

## Interface
Parameters:
- TIMEOUT, default 1023: cycles allowed in any host-wait state before abort.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- fetch_req  in  1  fetch requester wants a read
- fetch_addr  in  16  fetch address, latched at grant
- fetch_gnt  out  1  one-cycle pulse: fetch request accepted
- fetch_done  out  1  one-cycle pulse: fetch transaction finished
- mem_req  in  1  load/store requester wants a transaction
- mem_we  in  1  1 = store, 0 = load; latched at grant
- mem_addr  in  16  load/store address, latched at grant
- mem_wdata  in  16  store data, latched at grant
- mem_gnt  out  1  one-cycle pulse: mem request accepted
- mem_done  out  1  one-cycle pulse: mem transaction finished
- rdata  out  16  read result; valid while either done is high
- txn_err  out  1  high with done when the transaction timed out
- err_sticky  out  1  set on any timeout; cleared only by rst
- ard_receive_ready  in  1  host can accept bytes
- ard_data_ready  in  1  host is presenting the first response byte
- bus_in  in  8  response byte from host
- bus_out  out  8  byte to host; 0 when bus_oe low
- bus_oe  out  1  arbiter is driving bus_out this cycle
- bus_we  out  1  latched write flag; 0 when idle
- busy  out  1  high in every state except IDLE

## Operation
- **States:** IDLE, WAIT_RDY, ADDR_HI, ADDR_LO, DATA_HI, DATA_LO, WAIT_RESP, RESP_HI, RESP_LO, DONE.
- **IDLE:**
  - Requests are sampled only here.
  - If exactly one req is high, grant it.
  - If both are high, grant the side not granted last (round-robin). last_grant resets to fetch, so mem wins the first tie.
  - On grant: pulse the matching gnt, latch addr, we (fetch forces we=0) and wdata, then go to WAIT_RDY.
- **WAIT_RDY:** when ard_receive_ready = 1, go to ADDR_HI.
- **Address bytes:**
  - ADDR_HI drives addr[15:8]; ADDR_LO drives addr[7:0]. bus_oe = 1 in both.
  - After ADDR_LO: go to DATA_HI if we = 1, else WAIT_RESP.
- **Write data:**
  - DATA_HI drives wdata[15:8]; DATA_LO drives wdata[7:0]. bus_oe = 1.
  - After DATA_LO, go to DONE.
- **Read response:**
  - RESP_HI: captured in WAIT_RESP on the cycle ard_data_ready = 1: rdata[15:8] <= bus_in, go to RESP_LO.
  - RESP_LO: rdata[7:0] <= bus_in unconditionally, go to DONE.
- **DONE:** pulse the owner's done for one cycle, update last_grant, return to IDLE.
- **Requester obligation:** deassert req at the clock edge where done is high. A req still high in the following IDLE is treated as a new request.
- **Timeout:**
  - The counter clears on entry to WAIT_RDY and to WAIT_RESP, and counts while waiting.
  - When the count reaches TIMEOUT with the awaited signal still low: go to DONE with txn_err = 1, rdata = 16'h0000, set err_sticky.
  - A ready signal arriving on the expiry cycle wins; no abort.
- **Ignored inputs:**
  - While busy: req, addr, we and wdata changes.
  - Outside WAIT_RESP and RESP_LO: ard_data_ready and bus_in.
- **Reset, at any time including mid-transaction:**
  - State → IDLE.
  - All outputs 0: gnt, done, bus_out, bus_oe, bus_we, busy, txn_err, err_sticky, rdata.
  - last_grant → fetch; timeout counter → 0.
  - A partially sent transaction is abandoned, with no done pulse.

## Timing
- Cycle 0 = IDLE with req high; gnt is asserted in cycle 0. Outputs are Moore-decoded from state, except gnt, which is Mealy in IDLE.
- **Store, host ready immediately:** WAIT_RDY c1, ADDR_HI c2, ADDR_LO c3, DATA_HI c4, DATA_LO c5, DONE c6 (done high), IDLE c7.
- **Load, ready immediately, ard_data_ready high in c4:** WAIT_RESP c4, RESP_LO c5, DONE c6; rdata valid in c6.
- **Throughput:** minimum 7 cycles per transaction; back-to-back grants are spaced 7 cycles apart.
- Each wait state adds one cycle per cycle its ready input is low.
- rdata holds its last value until the next read's capture.

## Structure
- **Package ext_bus_pkg:**
  - typedef enum arb_state_t (states above);
  - typedef enum logic {REQ_FETCH, REQ_MEM} req_id_t;
  - localparam BYTE_W = 8 and ADDR_W = 16.
- **Sub-module wait_timer:**
  - Parameter TIMEOUT; inputs clk, rst, clear, en; output expired.
  - Counter width $clog2(TIMEOUT+1); saturates at TIMEOUT.

## Test plan
- **Single fetch, addr 16'h1234, host ready at once, ard_data_ready in c4 with bus_in 8'hAB then 8'hCD:**
  - fetch_gnt in c0;
  - bus_out 8'h12 in c2, 8'h34 in c3;
  - fetch_done in c6 with rdata 16'hABCD; bus_we = 0 throughout.
- **Store via mem_req, addr 16'h00F0, wdata 16'hBEEF:**
  - bus_out sequence 8'h00, 8'hF0, 8'hBE, 8'hEF in c2–c5, bus_we = 1;
  - mem_done in c6; no fetch signals toggle.
- **Both req high continuously after reset:**
  - grants alternate mem, fetch, mem, fetch, spaced 7 cycles apart.
- **ard_receive_ready held low with TIMEOUT = 15:**
  - DONE after 15 WAIT_RDY cycles, with txn_err = 1, rdata = 16'h0000, err_sticky = 1;
  - err_sticky stays 1 after the next successful transaction.
- **rst asserted in ADDR_LO of a store:**
  - next cycle: all outputs 0, state IDLE, no done pulse;
  - a subsequent simultaneous request grants mem.
- **mem_addr changed from 16'h1111 to 16'h2222 the cycle after grant:**
  - address bytes sent are 8'h11, 8'h11.
